// File: rtl/exc_redirect_ctrl_if.sv
// Exception/ERET redirect bundle between the WB/CP0 side, fetch, decode and exc_redirect_ctrl.
// Statistics counters are only meaningful when EXC_STAT_EN is defined.
interface exc_redirect_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             ws_valid;
  logic             ws_ex;
  logic             ws_eret;
  logic [31:0]      c0_epc;
  logic             has_int;
  logic             fs_ready;
  logic             flush;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             busy;
  logic             int_pending;
  logic [CNT_W-1:0] exc_cnt;
  logic [CNT_W-1:0] eret_cnt;

  modport master (
    output ws_valid, ws_ex, ws_eret, c0_epc, has_int, fs_ready,
    input  flush, redirect_valid, redirect_pc, busy, int_pending, exc_cnt, eret_cnt
  );

  modport slave (
    input  ws_valid, ws_ex, ws_eret, c0_epc, has_int, fs_ready,
    output flush, redirect_valid, redirect_pc, busy, int_pending, exc_cnt, eret_cnt
  );
endinterface

// File: rtl/exc_redirect_ctrl.sv
// Exception/ERET redirect controller: one-cycle flush, held redirect PC, post-accept drain.
// Optional saturating exception/ERET statistics counters under `define EXC_STAT_EN.
module exc_redirect_ctrl #(
  parameter logic [31:0] EX_ENTRY     = 32'hbfc00380,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             resetn,
  exc_redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REDIR, DRAIN} state_e;

  localparam bit         NO_DRAIN   = (DRAIN_CYCLES == 0);
  localparam logic [3:0] DRAIN_INIT = 4'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);

  state_e      state, state_d;
  logic [3:0]  drain_cnt, drain_cnt_d;
  logic        flush_q, flush_d;
  logic        rv_q, rv_d;
  logic [31:0] pc_q, pc_d;
  logic        int_q, int_d;
  logic        trigger;

  // Events arriving while busy belong to already-flushed instructions and are dropped.
  assign trigger = (state == IDLE) & bus.ws_valid & (bus.ws_ex | bus.ws_eret);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      drain_cnt <= '0;
      flush_q   <= 1'b0;
      rv_q      <= 1'b0;
      pc_q      <= '0;
      int_q     <= 1'b0;
    end else begin
      state     <= state_d;
      drain_cnt <= drain_cnt_d;
      flush_q   <= flush_d;
      rv_q      <= rv_d;
      pc_q      <= pc_d;
      int_q     <= int_d;
    end
  end

  always_comb begin
    state_d     = state;
    drain_cnt_d = drain_cnt;
    unique case (state)
      IDLE:  if (trigger) state_d = REDIR;
      REDIR: begin
        if (bus.fs_ready) begin
          if (NO_DRAIN) begin
            state_d = IDLE;
          end else begin
            state_d     = DRAIN;
            drain_cnt_d = DRAIN_INIT;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) state_d = IDLE;
        else                 drain_cnt_d = drain_cnt - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush_d = trigger;
    rv_d    = rv_q;
    pc_d    = pc_q;
    if (trigger) begin
      rv_d = 1'b1;
      pc_d = bus.ws_ex ? EX_ENTRY : bus.c0_epc;
    end else if ((state == REDIR) && bus.fs_ready) begin
      rv_d = 1'b0;
    end
    // Interrupts are only tagged when the controller will be idle and nothing is being taken.
    int_d = bus.has_int & (state_d == IDLE) & ~trigger;
  end

  assign bus.flush          = flush_q;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = pc_q;
  assign bus.int_pending    = int_q;
  assign bus.busy           = (state != IDLE);

`ifdef EXC_STAT_EN
  logic [CNT_W-1:0] exc_cnt_q, eret_cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      exc_cnt_q  <= '0;
      eret_cnt_q <= '0;
    end else if (trigger) begin
      if (bus.ws_ex) begin
        if (exc_cnt_q != '1) exc_cnt_q <= exc_cnt_q + 1'b1;
      end else if (eret_cnt_q != '1) begin
        eret_cnt_q <= eret_cnt_q + 1'b1;
      end
    end
  end

  assign bus.exc_cnt  = exc_cnt_q;
  assign bus.eret_cnt = eret_cnt_q;
`else
  assign bus.exc_cnt  = {CNT_W{1'b0}};
  assign bus.eret_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed vector bench for exc_redirect_ctrl (DRAIN_CYCLES=2, CNT_W=4) plus a DRAIN_CYCLES=0 instance.
// Counter expectations follow whether EXC_STAT_EN is defined.
module tb_exc_redirect_ctrl;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  exc_redirect_ctrl_if #(.CNT_W(4))  bus ();
  exc_redirect_ctrl_if #(.CNT_W(16)) b0 ();

  exc_redirect_ctrl #(.EX_ENTRY(32'hbfc00380), .DRAIN_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  exc_redirect_ctrl #(.EX_ENTRY(32'hbfc00380), .DRAIN_CYCLES(0), .CNT_W(16)) dut0 (
    .clk(clk), .resetn(resetn), .bus(b0)
  );

  typedef struct {
    logic        v, ex, er;
    logic [31:0] epc;
    logic        hi, fr;
    logic        fl, rv;
    logic [31:0] pc;
    logic        bz, ip;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  int n_cmp  = 0;
  int n_fail = 0;
  int n_flush;
  logic [3:0] exp_exc, exp_eret;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic v, logic ex, logic er, logic [31:0] epc, logic hi, logic fr,
                              logic fl, logic rv, logic [31:0] pc, logic bz, logic ip);
    vec_t r;
    r.v = v; r.ex = ex; r.er = er; r.epc = epc; r.hi = hi; r.fr = fr;
    r.fl = fl; r.rv = rv; r.pc = pc; r.bz = bz; r.ip = ip;
    return r;
  endfunction

  task automatic idle_inputs();
    bus.ws_valid = 1'b0; bus.ws_ex = 1'b0; bus.ws_eret = 1'b0;
    bus.c0_epc = '0; bus.has_int = 1'b0; bus.fs_ready = 1'b0;
  endtask

  initial begin
    idle_inputs();
    b0.ws_valid = 1'b0; b0.ws_ex = 1'b0; b0.ws_eret = 1'b0;
    b0.c0_epc = '0; b0.has_int = 1'b0; b0.fs_ready = 1'b0;
    resetn = 1'b0;
    repeat (2) tick();

    chk("rst flush", 32'(bus.flush), 32'd0);
    chk("rst redirect_valid", 32'(bus.redirect_valid), 32'd0);
    chk("rst redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst int_pending", 32'(bus.int_pending), 32'd0);
    chk("rst exc_cnt", 32'(bus.exc_cnt), 32'd0);
    chk("rst eret_cnt", 32'(bus.eret_cnt), 32'd0);

    resetn = 1'b1;

    //           v     ex    er    epc           hi    fr      fl    rv    pc            bz    ip
    // exception, immediate accept; ws_eret in REDIR and ws_ex in DRAIN are ignored
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1,   1'b1, 1'b1, 32'hbfc00380, 1'b1, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b1, 32'h11112222, 1'b0, 1'b1,   1'b0, 1'b0, 32'hbfc00380, 1'b1, 1'b0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 32'h33334444, 1'b0, 1'b1,   1'b0, 1'b0, 32'hbfc00380, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1,   1'b0, 1'b0, 32'hbfc00380, 1'b0, 1'b0);
    // ERET with fetch stalled three cycles; EPC changes afterwards must not leak through
    tbl[4]  = mk(1'b1, 1'b0, 1'b1, 32'hbfc01234, 1'b0, 1'b0,   1'b1, 1'b1, 32'hbfc01234, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 32'hdeadbeef, 1'b0, 1'b0,   1'b0, 1'b1, 32'hbfc01234, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 32'hdeadbeef, 1'b0, 1'b0,   1'b0, 1'b1, 32'hbfc01234, 1'b1, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 32'hdeadbeef, 1'b0, 1'b0,   1'b0, 1'b1, 32'hbfc01234, 1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1,   1'b0, 1'b0, 32'hbfc01234, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0,   1'b0, 1'b0, 32'hbfc01234, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0,   1'b0, 1'b0, 32'hbfc01234, 1'b0, 1'b0);
    // ex and eret together: exception wins
    tbl[11] = mk(1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b1,   1'b1, 1'b1, 32'hbfc00380, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1,   1'b0, 1'b0, 32'hbfc00380, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0,   1'b0, 1'b0, 32'hbfc00380, 1'b1, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0,   1'b0, 1'b0, 32'hbfc00380, 1'b0, 1'b0);
    // ws_ex without ws_valid does not trigger
    tbl[15] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1,   1'b0, 1'b0, 32'hbfc00380, 1'b0, 1'b0);
    // has_int held across an exception
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0,   1'b0, 1'b0, 32'hbfc00380, 1'b0, 1'b1);
    tbl[17] = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1,   1'b1, 1'b1, 32'hbfc00380, 1'b1, 1'b0);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1,   1'b0, 1'b0, 32'hbfc00380, 1'b1, 1'b0);
    tbl[19] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0,   1'b0, 1'b0, 32'hbfc00380, 1'b1, 1'b0);
    tbl[20] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0,   1'b0, 1'b0, 32'hbfc00380, 1'b0, 1'b1);
    tbl[21] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0,   1'b0, 1'b0, 32'hbfc00380, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      bus.ws_valid = tbl[i].v;  bus.ws_ex   = tbl[i].ex; bus.ws_eret  = tbl[i].er;
      bus.c0_epc   = tbl[i].epc; bus.has_int = tbl[i].hi; bus.fs_ready = tbl[i].fr;
      tick();
      chk($sformatf("v%0d flush", i), 32'(bus.flush), 32'(tbl[i].fl));
      chk($sformatf("v%0d redirect_valid", i), 32'(bus.redirect_valid), 32'(tbl[i].rv));
      chk($sformatf("v%0d redirect_pc", i), bus.redirect_pc, tbl[i].pc);
      chk($sformatf("v%0d busy", i), 32'(bus.busy), 32'(tbl[i].bz));
      chk($sformatf("v%0d int_pending", i), 32'(bus.int_pending), 32'(tbl[i].ip));
    end
    idle_inputs();

`ifdef EXC_STAT_EN
    exp_exc = 4'd3; exp_eret = 4'd1;
`else
    exp_exc = 4'd0; exp_eret = 4'd0;
`endif
    chk("tbl exc_cnt", 32'(bus.exc_cnt), 32'(exp_exc));
    chk("tbl eret_cnt", 32'(bus.eret_cnt), 32'(exp_eret));

    // Reset while a redirect is outstanding
    bus.ws_valid = 1'b1; bus.ws_eret = 1'b1; bus.c0_epc = 32'hbfc0abcd;
    tick();
    idle_inputs();
    chk("pre-rst redirect_valid", 32'(bus.redirect_valid), 32'd1);
    resetn = 1'b0;
    tick();
    chk("midrst redirect_valid", 32'(bus.redirect_valid), 32'd0);
    chk("midrst busy", 32'(bus.busy), 32'd0);
    chk("midrst flush", 32'(bus.flush), 32'd0);
    chk("midrst redirect_pc", bus.redirect_pc, 32'd0);
    chk("midrst exc_cnt", 32'(bus.exc_cnt), 32'd0);
    resetn = 1'b1;
    tick();
    bus.ws_valid = 1'b1; bus.ws_eret = 1'b1; bus.c0_epc = 32'hbfc05678; bus.fs_ready = 1'b1;
    tick();
    bus.ws_valid = 1'b0; bus.ws_eret = 1'b0; bus.c0_epc = '0;
    chk("post-rst flush", 32'(bus.flush), 32'd1);
    chk("post-rst redirect_pc", bus.redirect_pc, 32'hbfc05678);
    repeat (3) tick();
    chk("post-rst idle", 32'(bus.busy), 32'd0);
`ifdef EXC_STAT_EN
    exp_eret = 4'd1;
`else
    exp_eret = 4'd0;
`endif
    chk("post-rst eret_cnt", 32'(bus.eret_cnt), 32'(exp_eret));

    // 17 back-to-back exceptions: counter saturation and one flush per exception
    n_flush = 0;
    for (int k = 0; k < 17; k++) begin
      bus.ws_valid = 1'b1; bus.ws_ex = 1'b1; bus.fs_ready = 1'b1;
      tick();
      n_flush += int'(bus.flush);
      bus.ws_valid = 1'b0; bus.ws_ex = 1'b0;
      for (int j = 0; j < 3; j++) begin
        tick();
        n_flush += int'(bus.flush);
      end
    end
    idle_inputs();
    chk("sat flush count", 32'(n_flush), 32'd17);
`ifdef EXC_STAT_EN
    exp_exc = 4'hf;
`else
    exp_exc = 4'h0;
`endif
    chk("sat exc_cnt", 32'(bus.exc_cnt), 32'(exp_exc));
    chk("sat eret_cnt", 32'(bus.eret_cnt), 32'(exp_eret));

    // DRAIN_CYCLES=0: idle directly on the accepting edge
    b0.has_int = 1'b1; b0.ws_valid = 1'b1; b0.ws_ex = 1'b1; b0.fs_ready = 1'b1;
    tick();
    b0.ws_valid = 1'b0; b0.ws_ex = 1'b0;
    chk("d0 trig flush", 32'(b0.flush), 32'd1);
    chk("d0 trig busy", 32'(b0.busy), 32'd1);
    chk("d0 trig int_pending", 32'(b0.int_pending), 32'd0);
    tick();
    chk("d0 acc busy", 32'(b0.busy), 32'd0);
    chk("d0 acc redirect_valid", 32'(b0.redirect_valid), 32'd0);
    chk("d0 acc int_pending", 32'(b0.int_pending), 32'd1);
    chk("d0 acc flush", 32'(b0.flush), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
